// File: rtl/vproc_vregwr_arbiter.sv
// rtl/vproc_vregwr_arbiter.sv - round-robin VRF write port arbiter with burst lock and registered output
module vproc_vregwr_arbiter #(
    parameter int unsigned REQ_CNT  = 3,
    parameter int unsigned VPORT_W  = 128,
    parameter int unsigned VADDR_W  = 5,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                            clk_i,
    input  logic                            async_rst_ni,
    input  logic [REQ_CNT-1:0]              req_valid_i,
    output logic [REQ_CNT-1:0]              req_ready_o,
    input  logic [REQ_CNT-1:0]              req_lock_i,
    input  logic [REQ_CNT*VADDR_W-1:0]      req_addr_i,
    input  logic [REQ_CNT*VPORT_W/8-1:0]    req_be_i,
    input  logic [REQ_CNT*VPORT_W-1:0]      req_data_i,
    output logic                            vreg_wr_valid_o,
    input  logic                            vreg_wr_ready_i,
    output logic [VADDR_W-1:0]              vreg_wr_addr_o,
    output logic [VPORT_W/8-1:0]            vreg_wr_be_o,
    output logic [VPORT_W-1:0]              vreg_wr_data_o,
    output logic                            lock_active_o,
    output logic [$clog2(REQ_CNT)-1:0]      lock_owner_o
);

    localparam int unsigned IDX_W = $clog2(REQ_CNT);
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
    localparam int unsigned BE_W  = VPORT_W / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;

    logic               out_valid_q, out_valid_d;
    logic [VADDR_W-1:0] out_addr_q;
    logic [BE_W-1:0]    out_be_q;
    logic [VPORT_W-1:0] out_data_q;

    logic               out_free;
    logic               gnt_found;
    logic [IDX_W-1:0]   gnt_idx;
    logic               hs;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(REQ_CNT - 1)) ? '0 : i + 1'b1;
    endfunction

    assign out_free = ~out_valid_q | vreg_wr_ready_i;

    // Search starts at rr_ptr and wraps; while locked only the owner is eligible.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        cand      = '0;
        if (state_q == LOCKED) begin
            gnt_found = req_valid_i[owner_q];
            gnt_idx   = owner_q;
        end else begin
            for (int k = 0; k < int'(REQ_CNT); k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= int'(REQ_CNT)) begin
                    idx = idx - int'(REQ_CNT);
                end
                cand = IDX_W'(idx);
                if (!gnt_found && req_valid_i[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    assign hs          = gnt_found & out_free & async_rst_ni;
    assign req_ready_o = hs ? (REQ_CNT'(1) << gnt_idx) : '0;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        if (hs) begin
            if (state_q == LOCKED) begin
                // Beat that brings the count to LOCK_MAX releases even with lock held.
                if (!req_lock_i[owner_q] || (lock_cnt_q == CNT_W'(LOCK_MAX - 1))) begin
                    state_d    = IDLE;
                    rr_ptr_d   = next_idx(owner_q);
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end else if (req_lock_i[gnt_idx] && (LOCK_MAX > 1)) begin
                state_d    = LOCKED;
                owner_d    = gnt_idx;
                lock_cnt_d = CNT_W'(1);
            end else begin
                rr_ptr_d = next_idx(gnt_idx);
            end
        end
    end

    assign out_valid_d = out_free ? hs : out_valid_q;

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Payload is only written on a handshake, which already implies out_free.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            out_addr_q <= req_addr_i[gnt_idx*VADDR_W +: VADDR_W];
            out_be_q   <= req_be_i[gnt_idx*BE_W +: BE_W];
            out_data_q <= req_data_i[gnt_idx*VPORT_W +: VPORT_W];
        end
    end

    assign vreg_wr_valid_o = out_valid_q;
    assign vreg_wr_addr_o  = out_addr_q;
    assign vreg_wr_be_o    = out_be_q;
    assign vreg_wr_data_o  = out_data_q;
    assign lock_active_o   = (state_q == LOCKED);
    assign lock_owner_o    = owner_q;

endmodule

// File: tb/tb_vproc_vregwr_arbiter.sv
// tb/tb_vproc_vregwr_arbiter.sv - scoreboard bench for the VRF write port arbiter
module tb_vproc_vregwr_arbiter;

    localparam int N        = 3;
    localparam int W        = 128;
    localparam int A        = 5;
    localparam int BE       = W / 8;
    localparam int LOCK_MAX = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid_i, req_ready_o, req_lock_i;
    logic [N*A-1:0]   req_addr_i;
    logic [N*BE-1:0]  req_be_i;
    logic [N*W-1:0]   req_data_i;
    logic             vreg_wr_valid_o, vreg_wr_ready_i;
    logic [A-1:0]     vreg_wr_addr_o;
    logic [BE-1:0]    vreg_wr_be_o;
    logic [W-1:0]     vreg_wr_data_o;
    logic             lock_active_o;
    logic [1:0]       lock_owner_o;

    always #5 clk = ~clk;

    vproc_vregwr_arbiter #(.REQ_CNT(N), .VPORT_W(W), .VADDR_W(A), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_i(clk), .async_rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_lock_i(req_lock_i),
        .req_addr_i(req_addr_i), .req_be_i(req_be_i), .req_data_i(req_data_i),
        .vreg_wr_valid_o(vreg_wr_valid_o), .vreg_wr_ready_i(vreg_wr_ready_i),
        .vreg_wr_addr_o(vreg_wr_addr_o), .vreg_wr_be_o(vreg_wr_be_o), .vreg_wr_data_o(vreg_wr_data_o),
        .lock_active_o(lock_active_o), .lock_owner_o(lock_owner_o)
    );

    typedef struct {
        logic [A-1:0]  addr;
        logic [BE-1:0] be;
        logic [W-1:0]  data;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    gnt_log[$];

    logic  pend_v    [N];
    logic  pend_lock [N];
    beat_t pend_b    [N];
    logic  vr;

    int    m_rr, m_owner, m_cnt;
    bit    m_locked, m_out_valid;
    bit    prev_hs;
    logic [A-1:0] prev_addr;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int glog(input int k);
        return (gnt_log.size() > k) ? gnt_log[k] : -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]            = pend_v[i];
            req_lock_i[i]             = pend_lock[i];
            req_addr_i[i*A +: A]      = pend_b[i].addr;
            req_be_i[i*BE +: BE]      = pend_b[i].be;
            req_data_i[i*W +: W]      = pend_b[i].data;
        end
        vreg_wr_ready_i = vr;
    endtask

    task automatic new_req(input int i, input bit lock, input logic [A-1:0] addr);
        pend_v[i]         = 1'b1;
        pend_lock[i]      = lock;
        pend_b[i].addr    = addr;
        pend_b[i].be      = BE'($urandom);
        pend_b[i].data    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic model_reset();
        m_rr = 0; m_owner = 0; m_cnt = 0;
        m_locked = 0; m_out_valid = 0; prev_hs = 0;
        exp_q.delete();
        gnt_log.delete();
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_lock[i] = 1'b0;
            pend_b[i] = '{addr: '0, be: '0, data: '0};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        vr = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: drive, predict the grant from the arbitration rules, compare, then advance the model.
    task automatic cycle();
        int           g;
        bit           free, hs;
        logic [N-1:0] exp_ready;
        drive();
        @(negedge clk);
        free = !m_out_valid || vr;
        g = -1;
        if (m_locked) begin
            if (pend_v[m_owner]) g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend_v[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        hs = (g >= 0) && free;
        exp_ready = '0;
        if (hs) exp_ready[g] = 1'b1;
        check("req_ready", W'(req_ready_o), W'(exp_ready));
        check("lock_active", W'(lock_active_o), W'(m_locked));
        if (m_locked) check("lock_owner", W'(lock_owner_o), W'(m_owner));
        check("wr_valid", W'(vreg_wr_valid_o), W'(m_out_valid));
        if (prev_hs) check("latency_addr", W'(vreg_wr_addr_o), W'(prev_addr));
        prev_hs = hs;
        if (hs) begin
            exp_q.push_back(pend_b[g]);
            gnt_log.push_back(g);
            prev_addr = pend_b[g].addr;
            if (m_locked) begin
                m_cnt++;
                if (!pend_lock[g] || m_cnt == LOCK_MAX) begin
                    m_locked = 0;
                    m_rr = (m_owner + 1) % N;
                end
            end else if (pend_lock[g] && LOCK_MAX > 1) begin
                m_locked = 1; m_owner = g; m_cnt = 1;
            end else begin
                m_rr = (g + 1) % N;
            end
            pend_v[g] = 1'b0;
        end
        m_out_valid = hs ? 1'b1 : (free ? 1'b0 : m_out_valid);
        @(posedge clk);
        #1;
    endtask

    // Output side: the presented beat must equal the oldest accepted one, held until taken.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && vreg_wr_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got addr %0h expected no write", vreg_wr_addr_o);
            end else begin
                check("out_addr", W'(vreg_wr_addr_o), W'(exp_q[0].addr));
                check("out_be", W'(vreg_wr_be_o), W'(exp_q[0].be));
                check("out_data", vreg_wr_data_o, exp_q[0].data);
                if (vreg_wr_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int issued;
        rst_n = 1'b0;
        vr = 1'b1;
        model_reset();
        drive();
        #1;
        check("reset_wr_valid", W'(vreg_wr_valid_o), 0);
        check("reset_lock", W'(lock_active_o), 0);
        do_reset();

        // Single requester back-to-back; rr_ptr ends at 2.
        for (int i = 0; i < 4; i++) begin
            new_req(1, 0, A'(i + 1));
            cycle();
        end
        check("t1_count", W'(gnt_log.size()), 4);
        gnt_log.delete();
        new_req(0, 0, 5'd20);
        new_req(2, 0, 5'd22);
        cycle();
        check("t1_rr_ptr", W'(glog(0)), 2);

        // Plain round robin.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) if (!pend_v[i]) new_req(i, 0, A'(10 + i));
            cycle();
        end
        for (int k = 0; k < 6; k++) check("t2_order", W'(glog(k)), W'(k % N));

        // Backpressure.
        do_reset();
        new_req(2, 0, 5'd7);
        cycle();
        vr = 1'b0;
        new_req(0, 0, 5'd3);
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("t3_stall_valid", W'(vreg_wr_valid_o), 1);
            check("t3_stall_addr", W'(vreg_wr_addr_o), 7);
        end
        vr = 1'b1;
        cycle();
        check("t3_first", W'(glog(0)), 2);
        check("t3_wrap", W'(glog(1)), 0);

        // Lock burst: three locked beats then an unlocked final beat.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) new_req(1, k < 3, A'(k));
            if (k > 0 && !pend_v[0]) new_req(0, 0, 5'd31);
            cycle();
            if (k < 3) check("t4_lock_active", W'(lock_active_o), 1);
        end
        for (int k = 0; k < 4; k++) check("t4_burst", W'(glog(k)), 1);
        check("t4_after", W'(glog(4)), 0);

        // Forced release after LOCK_MAX beats.
        do_reset();
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            if (!pend_v[0] && issued < 12) begin
                new_req(0, 1, A'(issued));
                issued++;
            end
            if (!pend_v[2]) new_req(2, 0, 5'd9);
            cycle();
            if (c == LOCK_MAX - 1) check("t5_released", W'(lock_active_o), 0);
        end
        for (int k = 0; k < LOCK_MAX; k++) check("t5_owner", W'(glog(k)), 0);
        check("t5_next", W'(glog(LOCK_MAX)), 2);

        // Async reset mid-burst with a write pending at the output.
        do_reset();
        new_req(1, 1, 5'd1);
        cycle();
        new_req(1, 1, 5'd2);
        cycle();
        #2 rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) new_req(i, 0, A'(i + 4));
        drive();
        #1;
        check("t6_wr_valid", W'(vreg_wr_valid_o), 0);
        check("t6_lock", W'(lock_active_o), 0);
        check("t6_ready", W'(req_ready_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        check("t6_first", W'(glog(0)), 0);

        // Randomized traffic with random backpressure and locks.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            vr = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++)
                if (!pend_v[i] && ($urandom % 2) == 1) new_req(i, ($urandom % 3) == 0, A'($urandom));
            cycle();
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        vr = 1'b1;
        repeat (3) cycle();
        check("drain_empty", W'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
